// File: rtl/count_snap_pkg.sv
// count_snap_pkg: shared sample width and stored entry layout for the count snapshot FIFO
package count_snap_pkg;
   localparam int SNAP_WIDTH = 8;
   typedef struct packed {
      logic                  wrap;
      logic [SNAP_WIDTH-1:0] data;
   } snap_entry_t;
endpackage

// File: rtl/snap_fifo_core.sv
// snap_fifo_core: generic synchronous first-word-fall-through FIFO with occupancy count
module snap_fifo_core #(
   parameter int W = 9,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   // storage needs no reset; the head is only meaningful while not empty
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   // pointers wrap naturally; occupancy tracks push/pop balance
   always_ff @(posedge clk)
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   assign dout  = mem[rd_ptr];
   assign full  = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
endmodule

// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: captures counter samples with a wrap flag into a small FIFO drained over valid/ready
module count_snapshot_fifo
   import count_snap_pkg::*;
#(
   parameter int WIDTH = SNAP_WIDTH,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             snap_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_wrap,
   output logic [AW:0]      level,
   output logic             full,
   output logic             overflow,
   input  logic             clr_ovf
);
   logic             push, pop, drop, wrap, empty, last_valid;
   logic [WIDTH-1:0] last_cap;
   logic [WIDTH:0]   head;
   assign pop       = out_valid && out_ready;
   assign push      = snap_i && (!full || pop);
   assign drop      = snap_i && full && !pop;
   assign wrap      = last_valid && (cnt_i < last_cap);
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : head[WIDTH-1:0];
   assign out_wrap  = !empty && head[WIDTH];
   snap_fifo_core #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_core (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({wrap, cnt_i}),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );
   // remember the last accepted sample; dropped captures leave it untouched
   always_ff @(posedge clk)
      if (rst) begin
         last_cap   <= '0;
         last_valid <= 1'b0;
      end else if (push) begin
         last_cap   <= cnt_i;
         last_valid <= 1'b1;
      end
   // sticky drop indicator; a drop in the clearing cycle keeps it set
   always_ff @(posedge clk)
      if (rst) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream consumer of the 8-bit free-running counter (cnt output of the counter stage).
- On each capture strobe, stores the current count, plus a wrap flag, into a small synchronous FIFO.
- A consumer drains the FIFO over a valid/ready interface.
- Used to timestamp events against the counter without stalling the counter or its producer.

Parameters:
- WIDTH, 8, counter/sample width in bits.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cnt_i  in  WIDTH  current counter value from upstream counter stage.
- snap_i  in  1  capture strobe; one sample per asserted cycle.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  WIDTH  head sample value; 0 when empty.
- out_wrap  out  1  head sample is numerically below the previously accepted sample; 0 when empty.
- level  out  AW+1  entries currently stored, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky: a capture was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset values (rst high at clock edge):
  - rd_ptr, wr_ptr, level = 0; out_valid = 0; full = 0; overflow = 0.
  - last_valid = 0; last_cap = 0.
  - Storage contents are don't-care; outputs are gated by empty.
- Reset mid-operation discards all stored entries; the first capture after reset has wrap = 0.
- Push:
  - push = snap_i && (!full || pop).
  - Entry written = {wrap, cnt_i} at mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop:
  - pop = out_valid && out_ready; rd_ptr increments modulo DEPTH.
  - out_ready while empty is ignored.
- Level update:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
- Latency:
  - snap_i in cycle N gives out_valid = 1 in cycle N+1 (first-word-fall-through).
  - out_data/out_wrap are driven from stored state, not combinationally from cnt_i.
- Wrap detection:
  - wrap = last_valid && (cnt_i < last_cap), unsigned compare.
  - On an accepted push: last_cap <= cnt_i, last_valid <= 1.
  - Dropped captures do not update last_cap.
- Full and snap without pop:
  - Sample is dropped; overflow <= 1; FIFO state unchanged.
- Full and snap with pop in the same cycle:
  - Both occur; level stays DEPTH; no overflow.
- Empty and snap:
  - Write only; a pop cannot occur because out_valid = 0.
- Overflow flag:
  - clr_ovf clears overflow.
  - If a drop occurs in the same cycle as clr_ovf, set wins (overflow = 1).
- Equal values:
  - cnt_i == last_cap gives wrap = 0, e.g. a held counter.
- Pointers:
  - Width AW, natural wrap; full/empty are derived from level, not from pointer compare.

Decomposition:
- Package count_snap_pkg:
  - Localparam SNAP_WIDTH = 8.
  - Typedef snap_entry_t struct packed {logic wrap; logic [SNAP_WIDTH-1:0] data;}.
- Sub-module snap_fifo_core:
  - Generic synchronous FWFT FIFO (push, pop, data in/out, level, full, empty).
- The top level holds wrap detection (last_cap/last_valid), drop/overflow logic, and output gating.

Test Plan:
- Reset, then snap_i one cycle with cnt_i = 8'h05:
  - Next cycle out_valid = 1, out_data = 5, out_wrap = 0, level = 1.
- Captures 8'hFE, 8'hFF, 8'h00, 8'h01 with out_ready = 0:
  - level = 4, full = 1.
  - Drain yields 0xFE/0, 0xFF/0, 0x00/1, 0x01/0.
- Full FIFO, fifth snap with out_ready = 0:
  - overflow = 1, level stays 4, contents unchanged.
  - Then clr_ovf together with another dropped snap: overflow stays 1.
- Full FIFO, snap (cnt_i = 8'h20) and out_ready both high:
  - Head popped, level = 4, overflow = 0, 0x20 emerges last.
- Continuous snap with out_ready = 1, counter incrementing 0..15:
  - out_data follows cnt_i delayed one cycle; level stays 1; all wrap = 0.
- rst asserted with 3 entries stored:
  - Next cycle out_valid = 0, level = 0, out_data = 0.
  - First capture after reset (cnt_i = 8'h00, following a previous 8'hF0) has wrap = 0.
